// File: rtl/result_unloader.sv
// result_unloader: drains the 18-bit result memory (mat3) after the MAC loop.
// Every entry is read once through the synchronous mat3 read port, captured
// into a hold register and streamed as three DATA_WIDTH-bit bytes, low byte
// first, on a valid/ready interface.
module result_unloader #(
   parameter int DATA_WIDTH = 8,
   parameter int RES_WIDTH  = 18,
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  m3EN,
   output logic                  m3rEN,
   output logic [ADDR_WIDTH-1:0] addr3,
   input  logic [RES_WIDTH-1:0]  result_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            shift_cnt
);

   // Index of the final entry; reaching it routes the last transfer to DONE.
   localparam logic [ADDR_WIDTH-1:0] LAST_ELEM = ADDR_WIDTH'(ROWS * COLS - 1);
   // Width of the top partial byte (2 bits for the default 8/18 sizing).
   localparam int TOP_WIDTH = RES_WIDTH - 2 * DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      CAPT = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   elem_idx;
   logic [1:0]              byte_idx;
   logic [RES_WIDTH-1:0]    hold;
   logic                    xfer;
   logic                    last_byte;
   logic                    last_elem;

   assign xfer      = (state == SEND) && out_ready;
   assign last_byte = (byte_idx == 2'd2);
   assign last_elem = (elem_idx == LAST_ELEM);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a pending byte keeps the FSM in SEND until accepted.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = READ;
         READ: state_next = CAPT;
         CAPT: state_next = SEND;
         SEND: begin
            if (xfer && last_byte) begin
               state_next = last_elem ? DONE : READ;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Element/byte counters and the hold register that keeps the word stable
   // for all three byte transfers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         elem_idx <= '0;
         byte_idx <= '0;
         hold     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  elem_idx <= '0;
                  byte_idx <= '0;
               end
            end
            CAPT: hold <= result_in;
            SEND: begin
               if (xfer) begin
                  if (!last_byte) begin
                     byte_idx <= byte_idx + 2'd1;
                  end else begin
                     byte_idx <= '0;
                     // The final element never advances: the counter stays in range.
                     if (!last_elem) elem_idx <= elem_idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode: RAM controls only in READ, byte lane select only in SEND.
   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      m3EN      = (state == READ);
      m3rEN     = (state == READ);
      out_valid = (state == SEND);
      addr3     = elem_idx;
      shift_cnt = byte_idx;
      data_out  = '0;
      if (state == SEND) begin
         case (byte_idx)
            2'd0:    data_out = hold[DATA_WIDTH-1:0];
            2'd1:    data_out = hold[2*DATA_WIDTH-1:DATA_WIDTH];
            default: data_out = {{(DATA_WIDTH-TOP_WIDTH){1'b0}},
                                 hold[RES_WIDTH-1:2*DATA_WIDTH]};
         endcase
      end
   end

endmodule

// File: tb/tb_result_unloader.sv
// Bench for result_unloader: a mat3 memory model with synchronous read, a
// byte-stream reference built from the memory contents, and a negedge monitor
// that compares every accepted byte, every read address and stall stability.
module tb_result_unloader;

   localparam int DW    = 8;
   localparam int RW    = 18;
   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int AW    = 16;
   localparam int NELEM = ROWS * COLS;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic          m3EN;
   logic          m3rEN;
   logic [AW-1:0] addr3;
   logic [RW-1:0] result_in = '0;
   logic [DW-1:0] data_out;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1:0]    shift_cnt;

   result_unloader #(
      .DATA_WIDTH(DW), .RES_WIDTH(RW), .ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .m3EN(m3EN), .m3rEN(m3rEN), .addr3(addr3), .result_in(result_in),
      .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
      .shift_cnt(shift_cnt)
   );

   always #5 clk = ~clk;

   // mat3 model: synchronous read, data valid the cycle after the enable.
   logic [RW-1:0] mem [NELEM];
   always @(posedge clk) begin
      if (m3EN && m3rEN) result_in <= mem[addr3];
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference stream: {shift index, byte} per accepted transfer, in order.
   logic [9:0]    exp_q[$];
   int            exp_addr;
   int            nbytes;
   int            ndone;
   int            nreads;
   bit            mon_en = 1'b0;
   bit            prev_stall;
   logic [DW-1:0] held_byte;
   logic [1:0]    held_cnt;

   task automatic build_model();
      logic [RW-1:0] w;
      exp_q.delete();
      for (int i = 0; i < NELEM; i++) begin
         w = mem[i];
         exp_q.push_back({2'd0, w[7:0]});
         exp_q.push_back({2'd1, w[15:8]});
         exp_q.push_back({2'd2, 6'd0, w[17:16]});
      end
      exp_addr   = 0;
      nbytes     = 0;
      ndone      = 0;
      nreads     = 0;
      prev_stall = 1'b0;
   endtask

   // Monitor, sampling away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (m3EN && m3rEN) begin
            check_val("read_addr", 32'(addr3), 32'(exp_addr));
            exp_addr++;
            nreads++;
         end
         if (out_valid) begin
            if (prev_stall) begin
               check_val("stall_data", 32'(data_out), 32'(held_byte));
               check_val("stall_cnt", 32'(shift_cnt), 32'(held_cnt));
            end
            if (!out_ready) begin
               prev_stall = 1'b1;
               held_byte  = data_out;
               held_cnt   = shift_cnt;
            end else begin
               prev_stall = 1'b0;
               if (exp_q.size() == 0) begin
                  check_val("extra_byte", 32'(nbytes), 32'(NELEM * 3));
               end else begin
                  logic [9:0] e;
                  e = exp_q.pop_front();
                  check_val("byte", 32'(data_out), 32'(e[7:0]));
                  check_val("shift_cnt", 32'(shift_cnt), 32'(e[9:8]));
               end
               nbytes++;
            end
         end else if (prev_stall) begin
            check_val("valid_dropped", 32'(out_valid), 32'd1);
            prev_stall = 1'b0;
         end
         if (done) ndone++;
      end
   end

   // Starts an unload and runs until done. ready_mode 0: always ready,
   // 1: random backpressure. restart_at: cycle at which start is re-pulsed.
   task automatic run_unload(input int ready_mode, input int restart_at,
                             output int cycles, output int first_valid);
      bit seen_done = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      first_valid = 0;
      cycles = 0;
      for (int c = 1; c <= 4000 && !seen_done; c++) begin
         @(posedge clk); #1;
         start = (c == restart_at);
         out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 4) >= 2);
         @(negedge clk);
         if (out_valid && first_valid == 0) first_valid = c;
         if (done) begin
            seen_done = 1'b1;
            cycles = c;
         end
      end
      if (!seen_done) check_val("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic fill_random();
      for (int i = 0; i < NELEM; i++) mem[i] = RW'($urandom);
   endtask

   initial begin
      int cycles;
      int first_valid;
      bit hit;

      // Reset state.
      #3;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_outs", 32'({done, m3EN, m3rEN, out_valid}), 32'd0);
      check_val("rst_addr3", 32'(addr3), 32'd0);
      check_val("rst_data", 32'({data_out, shift_cnt}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Idle for 10 cycles with start low.
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_val("idle", 32'({busy, m3EN, out_valid, done}), 32'd0);

      // Run 1: directed corner words, always ready, start re-pulsed mid-unload.
      fill_random();
      mem[0] = 18'h3FFFF;
      mem[1] = 18'h00000;
      mem[2] = 18'h10001;
      mem[3] = 18'h00100;
      mem[4] = 18'h2A5C3;
      mem[5] = 18'h12345;
      build_model();
      mon_en = 1'b1;
      run_unload(0, 50, cycles, first_valid);
      $display("run1: cycles=%0d first_valid=%0d bytes=%0d dones=%0d", cycles, first_valid, nbytes, ndone);
      check_val("latency_first_valid", 32'(first_valid), 32'd3);
      check_val("total_cycles", 32'(cycles), 32'(NELEM * 5 + 1));
      check_val("bytes_run1", 32'(nbytes), 32'(NELEM * 3));
      check_val("done_run1", 32'(ndone), 32'd1);
      check_val("reads_run1", 32'(nreads), 32'(NELEM));
      check_val("idle_after1", 32'(busy), 32'd0);

      // Run 2: random contents with random backpressure.
      fill_random();
      build_model();
      run_unload(1, 0, cycles, first_valid);
      $display("run2: cycles=%0d bytes=%0d dones=%0d reads=%0d", cycles, nbytes, ndone, nreads);
      check_val("bytes_run2", 32'(nbytes), 32'(NELEM * 3));
      check_val("done_run2", 32'(ndone), 32'd1);
      check_val("reads_run2", 32'(nreads), 32'(NELEM));

      // Run 3: reset during SEND of element 5, then a fresh unload.
      fill_random();
      build_model();
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk);
         if (out_valid && nbytes >= 15) hit = 1'b1;
      end
      check_val("reached_elem5", 32'(hit), 32'd1);
      #2;
      mon_en = 1'b0;
      rst = 1'b0;
      #1;
      $display("run3: reset asserted after %0d bytes", nbytes);
      check_val("async_valid", 32'(out_valid), 32'd0);
      check_val("async_busy", 32'(busy), 32'd0);
      check_val("async_addr3", 32'(addr3), 32'd0);
      check_val("no_done_abort", 32'(ndone), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      build_model();
      mon_en = 1'b1;
      run_unload(1, 0, cycles, first_valid);
      $display("run4: cycles=%0d bytes=%0d dones=%0d reads=%0d", cycles, nbytes, ndone, nreads);
      check_val("bytes_run4", 32'(nbytes), 32'(NELEM * 3));
      check_val("done_run4", 32'(ndone), 32'd1);
      check_val("reads_run4", 32'(nreads), 32'(NELEM));
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Drain stage downstream of the matrix-multiply datapath.
- After the MAC loop has filled the 18-bit result memory (mat3), this block sequentially reads every entry through the mat3 read port.
- Each entry is split into three DATA_WIDTH-bit bytes and streamed on a valid/ready output interface.
- It owns the addr3/m3EN/m3rEN controls during unload and drives shift_cnt with the current byte index.

Parameters:
- DATA_WIDTH, 8: output byte width.
- RES_WIDTH, 18: result word width. It equals 2*DATA_WIDTH+2.
- ROWS, 8: rows of the result matrix.
- COLS, 8: columns of the result matrix.
- ADDR_WIDTH, 16: width of addr3. Must match mat3 (m+n).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin unloading. Sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last byte of the last entry is accepted.
- m3EN  output  1  mat3 RAM enable.
- m3rEN  output  1  mat3 read enable.
- addr3  output  ADDR_WIDTH  mat3 linear address. Range 0..ROWS*COLS-1, row-major.
- result_in  input  RES_WIDTH  mat3 data_out.
- data_out  output  DATA_WIDTH  current output byte.
- out_valid  output  1  data_out holds a valid byte.
- out_ready  input  1  consumer accepts the byte at this edge when out_valid=1.
- shift_cnt  output  2  index of the byte currently presented (0..2).

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Element index and byte index reset to 0.
  - Hold register resets to 0.
  - Outputs: busy=0, done=0, m3EN=0, m3rEN=0, addr3=0, out_valid=0, data_out=0, shift_cnt=0.
- FSM states: IDLE, READ, CAPT, SEND, DONE.
- IDLE:
  - At a clock edge with start=1: element index <= 0, byte index <= 0, go to READ.
  - start=0 keeps the FSM in IDLE.
- READ:
  - m3EN=1, m3rEN=1, addr3=element index.
  - Next state is always CAPT.
  - mat3 has synchronous read: result_in is valid during the following cycle.
- CAPT:
  - The hold register latches result_in at the end of this cycle.
  - m3EN and m3rEN are 0.
  - Next state is SEND.
- SEND:
  - out_valid=1 and shift_cnt=byte index.
  - data_out by byte index:
    - 0 gives hold[7:0].
    - 1 gives hold[15:8].
    - 2 gives {6'b0, hold[17:16]}, i.e. zero-extended upper bits.
  - A transfer happens at a clock edge where out_valid=1 and out_ready=1.
  - Transfer at byte index <2: byte index increments and the FSM stays in SEND.
  - Transfer at byte index 2, element not last: byte index <= 0, element index increments, go to READ.
  - Transfer at byte index 2, last element (ROWS*COLS-1): go to DONE.
  - No transfer: state, index and data_out stay stable. data_out must not change while out_valid=1 and out_ready=0.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Next state is IDLE.
- addr3 holds the element index in all states. It is only meaningful while m3EN=1.
- Latency and throughput:
  - With start sampled at edge 0, the first out_valid rises after edge 2.
  - With out_ready tied to 1, each element takes 5 cycles (READ, CAPT, 3×SEND).
  - A full 8×8 unload takes 320 cycles plus the DONE cycle.
- start while busy=1 is ignored. There is no restart and no queuing.
- Reset mid-unload aborts immediately to IDLE. No done pulse is produced. A new start unloads again from address 0.
- The element counter never wraps past ROWS*COLS-1. The DONE transition takes precedence.

Test Plan:
- Reset then idle: rst=0 at any time -> all outputs 0. Idle 10 cycles with start=0 -> m3EN=0, out_valid=0, busy=0.
- Single-word split, ROWS=COLS=1, mat3[0]=18'h2A5C3, out_ready=1:
  - Bytes 8'hC3, 8'hA5, 8'h02 with shift_cnt 0, 1, 2.
  - done pulses once, 5 cycles after the start edge plus 1.
- Max value and ordering, ROWS=COLS=2, mat3 = {18'h3FFFF, 18'h00000, 18'h10001, 18'h00100}:
  - Byte stream FF FF 03 | 00 00 00 | 01 00 01 | 00 01 00.
  - addr3 read sequence 0, 1, 2, 3.
- Backpressure, mat3[0]=18'h12345:
  - Hold out_ready=0 for 4 cycles at each byte.
  - Each byte is held stable: 8'h45, then 8'h23, then 8'h01.
  - No extra m3rEN pulses, no byte dropped or duplicated.
- start during busy: pulse start again mid-unload -> ignored. Exactly ROWS*COLS*3 bytes and one done pulse.
- Reset mid-operation: assert rst=0 during SEND of element 5 -> out_valid=0 and busy=0 asynchronously. A new start re-reads from addr3=0.
